// File: rtl/rename_unit.sv
// rename_unit: WIDTH-wide register rename stage. It uses a speculative RAT,
// a committed RAT updated from retire, and a bitmap of free physical tags.
// A flush restores the committed mapping and rebuilds the free map in one cycle.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_valid/in_ready move a whole decode group, never part of one.
// out_valid/out_ready move a whole renamed group. While out_valid=1 and
// out_ready=0, out_* hold their values.
module rename_unit #(
   parameter int  WIDTH     = 2,
   parameter int  ARCH_REGS = 32,
   parameter int  PHYS_REGS = 64,
   localparam int AW        = $clog2(ARCH_REGS),
   localparam int PW        = $clog2(PHYS_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_rd_en,
   input  logic [WIDTH*AW-1:0] in_rs1,
   input  logic [WIDTH*AW-1:0] in_rs2,
   input  logic [WIDTH*AW-1:0] in_rd,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH*PW-1:0] out_p_rs1,
   output logic [WIDTH*PW-1:0] out_p_rs2,
   output logic [WIDTH*PW-1:0] out_p_rd,
   output logic [WIDTH*PW-1:0] out_p_old_rd,
   input  logic [WIDTH-1:0]    ret_valid,
   input  logic [WIDTH*AW-1:0] ret_rd,
   input  logic [WIDTH*PW-1:0] ret_p_rd,
   input  logic [WIDTH*PW-1:0] ret_p_old_rd
);

   logic [PW-1:0]        rat       [ARCH_REGS];
   logic [PW-1:0]        crat      [ARCH_REGS];
   logic [PW-1:0]        rat_n     [ARCH_REGS];
   logic [PW-1:0]        crat_n    [ARCH_REGS];
   logic [PHYS_REGS-1:0] free_map;
   logic [PHYS_REGS-1:0] commit_used;
   logic [PHYS_REGS-1:0] free_ret;
   logic [PHYS_REGS-1:0] used_n;
   logic [PHYS_REGS-1:0] pool;
   logic [PHYS_REGS-1:0] alloc_mask;
   logic [WIDTH-1:0]     wr;
   logic [PW:0]          need;
   logic [PW:0]          avail;
   logic [PW-1:0]        alloc_tag [WIDTH];
   logic                 found;
   logic                 accept;
   logic [WIDTH*PW-1:0]  p_rs1_c;
   logic [WIDTH*PW-1:0]  p_rs2_c;
   logic [WIDTH*PW-1:0]  p_rd_c;
   logic [WIDTH*PW-1:0]  p_old_c;

   // Writing slots, in ascending order, take the lowest remaining free tags.
   always_comb begin
      pool       = free_map;
      alloc_mask = '0;
      need       = '0;
      found      = 1'b0;
      wr         = '0;
      for (int k = 0; k < WIDTH; k++) begin
         wr[k]        = in_rd_en[k] && (in_rd[k*AW +: AW] != '0);
         need         = need + (PW+1)'(wr[k]);
         alloc_tag[k] = '0;
         found        = 1'b0;
         for (int p = 0; p < PHYS_REGS; p++) begin
            if (wr[k] && !found && pool[p]) begin
               alloc_tag[k]  = PW'(p);
               pool[p]       = 1'b0;
               alloc_mask[p] = 1'b1;
               found         = 1'b1;
            end
         end
      end
   end

   // Free-tag count uses only registered state, so retire has no comb path to in_ready.
   always_comb begin
      avail = '0;
      for (int p = 0; p < PHYS_REGS; p++) begin
         avail = avail + (PW+1)'(free_map[p]);
      end
   end

   assign in_ready = !flush && !reset && (!out_valid || out_ready) && (avail >= need);
   assign accept   = in_valid && in_ready;

   // Source and old-dest lookup: the nearest earlier writer in the group wins over the RAT.
   always_comb begin
      p_rs1_c = '0;
      p_rs2_c = '0;
      p_rd_c  = '0;
      p_old_c = '0;
      for (int j = 0; j < WIDTH; j++) begin
         p_rs1_c[j*PW +: PW] = rat[in_rs1[j*AW +: AW]];
         p_rs2_c[j*PW +: PW] = rat[in_rs2[j*AW +: AW]];
         p_old_c[j*PW +: PW] = rat[in_rd[j*AW +: AW]];
         for (int k = 0; k < WIDTH; k++) begin
            if (k < j && wr[k]) begin
               if (in_rd[k*AW +: AW] == in_rs1[j*AW +: AW]) p_rs1_c[j*PW +: PW] = alloc_tag[k];
               if (in_rd[k*AW +: AW] == in_rs2[j*AW +: AW]) p_rs2_c[j*PW +: PW] = alloc_tag[k];
               if (in_rd[k*AW +: AW] == in_rd[j*AW +: AW])  p_old_c[j*PW +: PW] = alloc_tag[k];
            end
         end
         if (in_rs1[j*AW +: AW] == '0) p_rs1_c[j*PW +: PW] = '0;
         if (in_rs2[j*AW +: AW] == '0) p_rs2_c[j*PW +: PW] = '0;
         if (wr[j]) p_rd_c[j*PW +: PW] = alloc_tag[j];
         else       p_old_c[j*PW +: PW] = '0;
      end
   end

   // Next committed state from retire (ascending slots), next speculative RAT from accept.
   always_comb begin
      crat_n   = crat;
      used_n   = commit_used;
      free_ret = free_map;
      rat_n    = rat;
      for (int k = 0; k < WIDTH; k++) begin
         if (ret_valid[k]) begin
            if (ret_p_rd[k*PW +: PW] != '0) begin
               crat_n[ret_rd[k*AW +: AW]]  = ret_p_rd[k*PW +: PW];
               used_n[ret_p_rd[k*PW +: PW]] = 1'b1;
            end
            if (ret_p_old_rd[k*PW +: PW] != '0) begin
               used_n[ret_p_old_rd[k*PW +: PW]]   = 1'b0;
               free_ret[ret_p_old_rd[k*PW +: PW]] = 1'b1;
            end
         end
         if (accept && wr[k]) rat_n[in_rd[k*AW +: AW]] = alloc_tag[k];
      end
   end

   // Mapping state: reset, then flush (committed view after retire), then normal update.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            rat[i]  <= PW'(i);
            crat[i] <= PW'(i);
         end
         for (int p = 0; p < PHYS_REGS; p++) begin
            free_map[p]    <= (p >= ARCH_REGS);
            commit_used[p] <= (p < ARCH_REGS);
         end
      end else begin
         crat        <= crat_n;
         commit_used <= used_n;
         if (flush) begin
            rat      <= crat_n;
            free_map <= ~used_n;
         end else begin
            rat      <= rat_n;
            free_map <= free_ret & ~({PHYS_REGS{accept}} & alloc_mask);
         end
      end
   end

   // Output register toward dispatch; data holds until a new group is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_p_rs1    <= '0;
         out_p_rs2    <= '0;
         out_p_rd     <= '0;
         out_p_old_rd <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         out_p_rs1    <= p_rs1_c;
         out_p_rs2    <= p_rs2_c;
         out_p_rd     <= p_rd_c;
         out_p_old_rd <= p_old_c;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: directed rename scenarios plus randomized traffic, checked
// against a sequential rename model (scratch RAT walked slot by slot, free
// list as a sorted set, committed state replayed from retire).
module tb_rename_unit;
   localparam int W    = 2;
   localparam int ARCH = 32;
   localparam int PHYS = 64;
   localparam int AW   = 5;
   localparam int PW   = 6;
   localparam int FW   = W*PW;
   localparam int OW   = 4*FW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_rd_en;
   logic [W*AW-1:0] in_rs1, in_rs2, in_rd;
   logic          out_valid;
   logic          out_ready;
   logic [FW-1:0] out_p_rs1, out_p_rs2, out_p_rd, out_p_old_rd;
   logic [W-1:0]  ret_valid;
   logic [W*AW-1:0] ret_rd;
   logic [FW-1:0] ret_p_rd, ret_p_old_rd;

   rename_unit #(.WIDTH(W), .ARCH_REGS(ARCH), .PHYS_REGS(PHYS)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_rd_en(in_rd_en),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_p_rs1(out_p_rs1), .out_p_rs2(out_p_rs2),
      .out_p_rd(out_p_rd), .out_p_old_rd(out_p_old_rd),
      .ret_valid(ret_valid), .ret_rd(ret_rd),
      .ret_p_rd(ret_p_rd), .ret_p_old_rd(ret_p_old_rd)
   );

   // clock
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference state
   int m_rat  [ARCH];
   int m_crat [ARCH];
   bit m_free [PHYS];
   bit m_cu   [PHYS];
   typedef struct { int rd; int p_rd; int p_old; } fl_t;
   fl_t fl_q[$];
   logic [OW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ARCH; i++) begin
         m_rat[i]  = i;
         m_crat[i] = i;
      end
      for (int p = 0; p < PHYS; p++) begin
         m_free[p] = (p >= ARCH);
         m_cu[p]   = (p < ARCH);
      end
      exp_q.delete();
      fl_q.delete();
   endtask

   task automatic clear_in();
      in_valid     = 1'b0;
      in_rd_en     = '0;
      in_rs1       = '0;
      in_rs2       = '0;
      in_rd        = '0;
      ret_valid    = '0;
      ret_rd       = '0;
      ret_p_rd     = '0;
      ret_p_old_rd = '0;
      flush        = 1'b0;
      out_ready    = 1'b1;
   endtask

   task automatic set_slot(input int k, input int en, input int rs1, input int rs2, input int rd);
      in_rd_en[k]          = (en != 0);
      in_rs1[k*AW +: AW]   = AW'(rs1);
      in_rs2[k*AW +: AW]   = AW'(rs2);
      in_rd[k*AW +: AW]    = AW'(rd);
   endtask

   // retire up to n oldest renamed instructions, in program order
   task automatic drive_retire(input int n);
      fl_t e;
      for (int k = 0; k < W; k++) begin
         if (k < n && fl_q.size() > 0) begin
            e = fl_q.pop_front();
            ret_valid[k]             = 1'b1;
            ret_rd[k*AW +: AW]       = AW'(e.rd);
            ret_p_rd[k*PW +: PW]     = PW'(e.p_rd);
            ret_p_old_rd[k*PW +: PW] = PW'(e.p_old);
         end
      end
   endtask

   task automatic rand_group();
      in_valid = ($urandom_range(0, 9) < 8);
      for (int k = 0; k < W; k++) begin
         set_slot(k, ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31),
                  $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31),
                  $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      end
   endtask

   // One clock: predict, check in_ready, step the model, check the output register.
   task automatic tick();
      int need, avail, rs1, rs2, rd, rp, rpo;
      bit wr [W];
      int a_tag [W];
      int tmp_rat [ARCH];
      int fl[$];
      logic exp_ready, acc;
      logic [FW-1:0] e_rs1, e_rs2, e_rd, e_old;
      logic [OW-1:0] grp;
      #1;
      need = 0;
      for (int k = 0; k < W; k++) begin
         wr[k] = in_rd_en[k] && (in_rd[k*AW +: AW] != 0);
         need += int'(wr[k]);
      end
      avail = 0;
      for (int p = 0; p < PHYS; p++) if (m_free[p]) fl.push_back(p);
      avail = fl.size();
      exp_ready = !flush && (exp_q.size() == 0 || out_ready) && (avail >= need);
      check("in_ready", in_ready, exp_ready);
      acc = in_valid && exp_ready;

      // sequential rename of the group against a scratch RAT
      tmp_rat = m_rat;
      e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_old = '0;
      for (int j = 0; j < W; j++) begin
         rs1 = int'(in_rs1[j*AW +: AW]);
         rs2 = int'(in_rs2[j*AW +: AW]);
         rd  = int'(in_rd[j*AW +: AW]);
         a_tag[j] = 0;
         if (wr[j] && fl.size() > 0) a_tag[j] = fl.pop_front();
         e_rs1[j*PW +: PW] = PW'((rs1 == 0) ? 0 : tmp_rat[rs1]);
         e_rs2[j*PW +: PW] = PW'((rs2 == 0) ? 0 : tmp_rat[rs2]);
         if (wr[j]) begin
            e_old[j*PW +: PW] = PW'(tmp_rat[rd]);
            e_rd[j*PW +: PW]  = PW'(a_tag[j]);
            tmp_rat[rd] = a_tag[j];
         end
      end
      grp = {e_rs1, e_rs2, e_rd, e_old};

      // committed state from retire
      for (int k = 0; k < W; k++) begin
         if (ret_valid[k]) begin
            rd  = int'(ret_rd[k*AW +: AW]);
            rp  = int'(ret_p_rd[k*PW +: PW]);
            rpo = int'(ret_p_old_rd[k*PW +: PW]);
            if (rp != 0) begin
               m_crat[rd] = rp;
               m_cu[rp]   = 1'b1;
            end
            if (rpo != 0) begin
               m_cu[rpo]   = 1'b0;
               m_free[rpo] = 1'b1;
            end
         end
      end

      if (flush) begin
         m_rat = m_crat;
         for (int p = 0; p < PHYS; p++) m_free[p] = !m_cu[p];
         fl_q.delete();
         exp_q.delete();
      end else begin
         if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
         if (acc) begin
            m_rat = tmp_rat;
            for (int j = 0; j < W; j++) begin
               if (wr[j]) m_free[a_tag[j]] = 1'b0;
               fl_q.push_back('{rd: int'(in_rd[j*AW +: AW]),
                                p_rd: int'(e_rd[j*PW +: PW]),
                                p_old: int'(e_old[j*PW +: PW])});
            end
            exp_q.push_back(grp);
         end
      end

      @(posedge clk);
      #1;
      check("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         grp = exp_q[0];
         check("out_p_rs1", out_p_rs1, grp[4*FW-1 -: FW]);
         check("out_p_rs2", out_p_rs2, grp[3*FW-1 -: FW]);
         check("out_p_rd", out_p_rd, grp[2*FW-1 -: FW]);
         check("out_p_old_rd", out_p_old_rd, grp[FW-1 -: FW]);
      end
      @(negedge clk);
   endtask

   task automatic check_ready_now(input string tag, input logic exp);
      #1;
      check(tag, in_ready, exp);
   endtask

   task automatic do_reset();
      clear_in();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_p_rd", out_p_rd, '0);
      check("rst_out_p_old_rd", out_p_old_rd, '0);
      check("rst_out_p_rs1", out_p_rs1, '0);
   endtask

   initial begin
      clear_in();
      do_reset();

      // T1: no writers, identity mapping
      clear_in();
      in_valid = 1'b1;
      set_slot(0, 0, 5, 6, 0);
      set_slot(1, 0, 0, 31, 0);
      check_ready_now("t1_ready", 1'b1);
      tick();
      check("t1_rs1", out_p_rs1[PW-1:0], 5);
      check("t1_rd", out_p_rd, '0);

      // T2: add x1,x2,x3 ; add x4,x1,x1
      clear_in();
      in_valid = 1'b1;
      set_slot(0, 1, 2, 3, 1);
      set_slot(1, 1, 1, 1, 4);
      tick();
      check("t2_rs1", out_p_rs1, {6'd32, 6'd2});
      check("t2_rs2", out_p_rs2, {6'd32, 6'd3});
      check("t2_rd", out_p_rd, {6'd33, 6'd32});
      check("t2_old", out_p_old_rd, {6'd4, 6'd1});

      // T3: two writers of x7 in one group
      do_reset();
      clear_in();
      in_valid = 1'b1;
      set_slot(0, 1, 0, 0, 7);
      set_slot(1, 1, 0, 0, 7);
      tick();
      check("t3_rd", out_p_rd, {6'd33, 6'd32});
      check("t3_old", out_p_old_rd, {6'd32, 6'd7});
      clear_in();
      in_valid = 1'b1;
      set_slot(0, 0, 7, 0, 0);
      tick();
      check("t3_read_x7", out_p_rs1[PW-1:0], 33);

      // T4: exhaust free tags
      do_reset();
      for (int g = 0; g < 16; g++) begin
         clear_in();
         in_valid = 1'b1;
         set_slot(0, 1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 31));
         set_slot(1, 1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 31));
         tick();
      end
      clear_in();
      in_valid = 1'b1;
      set_slot(0, 1, 1, 2, 3);
      set_slot(1, 1, 4, 5, 6);
      check_ready_now("t4_full", 1'b0);
      tick();
      clear_in();
      in_valid = 1'b1;
      set_slot(0, 1, 1, 2, 0);
      check_ready_now("t4_x0_only", 1'b1);
      tick();
      clear_in();
      in_valid = 1'b1;
      set_slot(1, 1, 1, 2, 9);
      check_ready_now("t4_one_writer", 1'b0);
      tick();

      // T5: output stall and release
      do_reset();
      clear_in();
      in_valid = 1'b1;
      set_slot(0, 1, 1, 2, 3);
      set_slot(1, 1, 3, 3, 4);
      tick();
      for (int c = 0; c < 3; c++) begin
         clear_in();
         out_ready = 1'b0;
         in_valid = 1'b1;
         set_slot(0, 1, 4, 3, 5);
         set_slot(1, 0, 5, 1, 6);
         check_ready_now("t5_stall", 1'b0);
         tick();
      end
      clear_in();
      in_valid = 1'b1;
      set_slot(0, 1, 4, 3, 5);
      set_slot(1, 0, 5, 1, 6);
      check_ready_now("t5_release", 1'b1);
      tick();

      // T6: three groups, retire the first, flush
      do_reset();
      clear_in();
      in_valid = 1'b1;
      set_slot(0, 1, 0, 0, 3);
      set_slot(1, 1, 0, 0, 9);
      tick();
      clear_in();
      in_valid = 1'b1;
      set_slot(0, 1, 3, 9, 10);
      set_slot(1, 1, 10, 0, 11);
      tick();
      clear_in();
      in_valid = 1'b1;
      set_slot(0, 1, 11, 2, 12);
      set_slot(1, 1, 0, 0, 13);
      tick();
      clear_in();
      drive_retire(2);
      tick();
      clear_in();
      flush = 1'b1;
      in_valid = 1'b1;
      set_slot(0, 1, 1, 1, 1);
      check_ready_now("t6_flush_ready", 1'b0);
      tick();
      check("t6_out_valid", out_valid, 1'b0);
      for (int r = 0; r < ARCH; r += 4) begin
         clear_in();
         in_valid = 1'b1;
         set_slot(0, 0, r, r + 1, 0);
         set_slot(1, 0, r + 2, r + 3, 0);
         tick();
      end
      clear_in();
      in_valid = 1'b1;
      set_slot(0, 1, 3, 9, 5);
      set_slot(1, 1, 10, 12, 6);
      tick();
      check("t6_alloc", out_p_rd, {6'd9, 6'd3});

      // randomized traffic, with a reset in the middle
      for (int phase = 0; phase < 2; phase++) begin
         for (int c = 0; c < 400; c++) begin
            clear_in();
            rand_group();
            out_ready = ($urandom_range(0, 9) < 7);
            drive_retire($urandom_range(0, 2));
            flush = ($urandom_range(0, 99) < 3);
            tick();
         end
         do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
